// File: rtl/input_pkg.sv
// Shared defaults, channel naming and a counter-width helper for the input conditioner.
package input_pkg;

   localparam int DEF_CLK_DIV      = 100000;
   localparam int DEF_STABLE_TICKS = 8;
   localparam int DEF_RPT_DELAY    = 500;
   localparam int DEF_RPT_RATE     = 100;

   typedef enum logic [2:0] {
      CH_UP,
      CH_RIGHT,
      CH_DOWN,
      CH_LEFT,
      CH_SEL
   } ch_idx_e;

   // Bits needed to hold 0..n_states-1, never less than one.
   function automatic int cnt_width(input int n_states);
      return (n_states > 1) ? $clog2(n_states) : 1;
   endfunction

endpackage

// File: rtl/debounce_channel.sv
// One conditioned input: 2-flop synchroniser, tick-based stability counter, edge pulses.
// Auto-repeat logic exists only when INPUT_CONDITIONER_AUTO_REPEAT_EN is defined.
module debounce_channel
   import input_pkg::*;
#(
   parameter int   STABLE_TICKS = DEF_STABLE_TICKS,
   parameter int   RPT_DELAY    = DEF_RPT_DELAY,
   parameter int   RPT_RATE     = DEF_RPT_RATE,
   parameter logic INV          = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic tick,
   input  logic raw,
   output logic level,
   output logic rise_pulse,
   output logic fall_pulse,
   output logic rpt_pulse
);

   localparam int              SW          = cnt_width(STABLE_TICKS);
   localparam logic [SW-1:0]   STABLE_LAST = SW'(STABLE_TICKS - 1);

   logic [1:0]    sync;
   logic [SW-1:0] stable_cnt;
   logic          differ;
   logic          accept;

   assign differ = sync[1] ^ level;
   assign accept = tick & differ & (stable_cnt == STABLE_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync <= 2'b00;
      end else begin
         sync <= {sync[0], raw ^ INV};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         level      <= 1'b0;
         stable_cnt <= '0;
         rise_pulse <= 1'b0;
         fall_pulse <= 1'b0;
      end else begin
         rise_pulse <= accept & ~level;
         fall_pulse <= accept & level;
         if (accept) begin
            level      <= ~level;
            stable_cnt <= '0;
         end else if (tick) begin
            stable_cnt <= differ ? stable_cnt + SW'(1) : '0;
         end
      end
   end

`ifdef INPUT_CONDITIONER_AUTO_REPEAT_EN
   localparam int RPT_MAX = (RPT_DELAY > RPT_RATE) ? RPT_DELAY : RPT_RATE;
   localparam int RW      = cnt_width(RPT_MAX + 1);

   logic [RW-1:0] rpt_left;
   logic          rpt_fire;

   // A release tick wins over a coincident repeat.
   assign rpt_fire = tick & level & ~accept & (rpt_left == RW'(1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rpt_left  <= '0;
         rpt_pulse <= 1'b0;
      end else begin
         rpt_pulse <= rpt_fire;
         if (accept) begin
            rpt_left <= level ? '0 : RW'(RPT_DELAY);
         end else if (rpt_fire) begin
            rpt_left <= RW'(RPT_RATE);
         end else if (tick && level && (rpt_left != '0)) begin
            rpt_left <= rpt_left - RW'(1);
         end
      end
   end
`else
   assign rpt_pulse = 1'b0;
`endif

endmodule

// File: rtl/input_conditioner.sv
// Input conditioner top: shared sample-tick generator feeding N_CH debounce channels.
// Auto-repeat is compiled in only when INPUT_CONDITIONER_AUTO_REPEAT_EN is defined.
module input_conditioner
   import input_pkg::*;
#(
   parameter int              N_CH         = 5,
   parameter int              CLK_DIV      = DEF_CLK_DIV,
   parameter int              STABLE_TICKS = DEF_STABLE_TICKS,
   parameter logic [N_CH-1:0] IN_INV       = '0,
   parameter int              RPT_DELAY    = DEF_RPT_DELAY,
   parameter int              RPT_RATE     = DEF_RPT_RATE
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [N_CH-1:0] raw_i,
   output logic [N_CH-1:0] level_o,
   output logic [N_CH-1:0] press_o,
   output logic [N_CH-1:0] release_o,
   output logic [N_CH-1:0] rpt_o,
   output logic            tick_o
);

   localparam int            DW       = cnt_width(CLK_DIV);
   localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

   logic [DW-1:0] div_cnt;
   logic [DW-1:0] div_next;

   always_comb begin
      div_next = (div_cnt == DIV_LAST) ? '0 : div_cnt + DW'(1);
   end

   // tick_o is registered from the next count so it is low throughout reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_cnt <= '0;
         tick_o  <= 1'b0;
      end else begin
         div_cnt <= div_next;
         tick_o  <= (div_next == DIV_LAST);
      end
   end

   for (genvar c = 0; c < N_CH; c++) begin : g_ch
      debounce_channel #(
         .STABLE_TICKS (STABLE_TICKS),
         .RPT_DELAY    (RPT_DELAY),
         .RPT_RATE     (RPT_RATE),
         .INV          (IN_INV[c])
      ) u_ch (
         .clk        (clk),
         .rst_n      (rst_n),
         .tick       (tick_o),
         .raw        (raw_i[c]),
         .level      (level_o[c]),
         .rise_pulse (press_o[c]),
         .fall_pulse (release_o[c]),
         .rpt_pulse  (rpt_o[c])
      );
   end

endmodule

// File: tb/tb_input_conditioner.sv
// Scoreboard bench for input_conditioner: tick-level reference model queues expected
// press/release/repeat events; an independent monitor pops and compares them.
module tb_input_conditioner;

   localparam int              N_CH    = 5;
   localparam int              CLK_DIV = 4;
   localparam int              ST      = 3;
   localparam int              RD      = 5;
   localparam int              RR      = 2;
   localparam logic [N_CH-1:0] INV     = 5'b00001;
`ifdef INPUT_CONDITIONER_AUTO_REPEAT_EN
   localparam bit RPT_ON = 1'b1;
`else
   localparam bit RPT_ON = 1'b0;
`endif

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic [N_CH-1:0] raw = '0;
   logic [N_CH-1:0] level, press, rel, rpt;
   logic            tick;

   input_conditioner #(
      .N_CH         (N_CH),
      .CLK_DIV      (CLK_DIV),
      .STABLE_TICKS (ST),
      .IN_INV       (INV),
      .RPT_DELAY    (RD),
      .RPT_RATE     (RR)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .raw_i     (raw),
      .level_o   (level),
      .press_o   (press),
      .release_o (rel),
      .rpt_o     (rpt),
      .tick_o    (tick)
   );

   always #5 clk = ~clk;

   // kind: 0 press, 1 release, 2 repeat
   typedef struct {
      int cyc;
      int ch;
      int kind;
   } ev_t;

   ev_t             exp_q[$];
   int              vectors = 0;
   int              miscompares = 0;
   int              k = 0;
   logic [N_CH-1:0] m_level = '0;
   int              run[N_CH];
   int              held[N_CH];
   logic [N_CH-1:0] eff_hist[$];

   task automatic check(input string name, input logic [N_CH-1:0] act,
                        input logic [N_CH-1:0] expv);
      vectors++;
      if (act !== expv) begin
         miscompares++;
         $display("FAIL %s at cycle %0d: got %b, expected %b", name, k, act, expv);
      end
   endtask

   // Reference model: edge k sees the effective input from edge k-2; ticks act on every
   // CLK_DIV-th edge after reset; ST consecutive differing ticks flip the level.
   always @(posedge clk) begin : model
      logic [N_CH-1:0] smp;
      bit              tog;
      if (!rst_n) begin
         k       = 0;
         m_level = '0;
         eff_hist.delete();
         for (int c = 0; c < N_CH; c++) begin
            run[c]  = 0;
            held[c] = 0;
         end
      end else begin
         k++;
         smp = (eff_hist.size() >= 2) ? eff_hist[eff_hist.size() - 2] : '0;
         eff_hist.push_back(raw ^ INV);
         if (eff_hist.size() > 4) void'(eff_hist.pop_front());
         if (k % CLK_DIV == 0) begin
            for (int c = 0; c < N_CH; c++) begin
               tog = 1'b0;
               if (smp[c] != m_level[c]) begin
                  run[c]++;
                  if (run[c] == ST) begin
                     tog        = 1'b1;
                     run[c]     = 0;
                     m_level[c] = ~m_level[c];
                     exp_q.push_back('{k, c, m_level[c] ? 0 : 1});
                     held[c] = 0;
                  end
               end else begin
                  run[c] = 0;
               end
               if (!tog && m_level[c]) begin
                  held[c]++;
                  if (RPT_ON && held[c] >= RD && ((held[c] - RD) % RR) == 0)
                     exp_q.push_back('{k, c, 2});
               end
            end
         end
      end
   end

   always @(posedge clk) begin : monitor
      logic [N_CH-1:0] ep, er, et;
      logic            exp_tick;
      ev_t             e;
      #1;
      ep = '0;
      er = '0;
      et = '0;
      while (exp_q.size() > 0 && exp_q[0].cyc <= k) begin
         e = exp_q.pop_front();
         case (e.kind)
            0:       ep[e.ch] = 1'b1;
            1:       er[e.ch] = 1'b1;
            default: et[e.ch] = 1'b1;
         endcase
      end
      exp_tick = rst_n && (((k + 1) % CLK_DIV) == 0);
      check("press", press, ep);
      check("release", rel, er);
      check("repeat", rpt, et);
      check("level", level, m_level);
      check("tick", {{(N_CH-1){1'b0}}, tick}, {{(N_CH-1){1'b0}}, exp_tick});
   end

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      logic [N_CH-1:0] flip;
      raw   = '0;
      rst_n = 1'b0;
      wait_cyc(3);
      rst_n = 1'b1;
      wait_cyc(30);                       // inverted channel 0 debounces to 1
      raw[4] = 1'b1;                      // clean press
      wait_cyc(30);
      raw[1] = 1'b1;                      // two-tick glitch, must be rejected
      wait_cyc(8);
      raw[1] = 1'b0;
      wait_cyc(30);
      raw[2] = 1'b1;                      // long hold for auto-repeat
      wait_cyc(40 * CLK_DIV);
      raw[2] = 1'b0;
      wait_cyc(30);
      raw = ~raw;                         // every channel flips together
      wait_cyc(40);
      raw = ~raw;
      wait_cyc(40);
      raw[3] = 1'b1;                      // reset mid-debounce, input stays high
      wait_cyc(10);
      rst_n = 1'b0;
      wait_cyc(4);
      rst_n = 1'b1;
      wait_cyc(40);
      for (int i = 0; i < 600; i++) begin
         flip = N_CH'($urandom) & N_CH'($urandom);
         raw  = raw ^ flip;
         if ($urandom_range(0, 59) == 0) begin
            rst_n = 1'b0;
            wait_cyc($urandom_range(1, 5));
            rst_n = 1'b1;
         end
         wait_cyc($urandom_range(1, 20));
      end
      wait_cyc(40);
      vectors++;
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL pending_events: got %0d left over, expected 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/input_conditioner.md
INPUT_CONDITIONER -- requirements
Module: input_conditioner

Interface
REQ-001 Parameter N_CH, 5, number of independent input channels (>=1).
REQ-002 Parameter CLK_DIV, 100000, clk cycles per sample tick (>=1); 100000 gives a 1 kHz tick at 100 MHz.
REQ-003 Parameter STABLE_TICKS, 8, consecutive differing ticks required to accept a new level (>=1).
REQ-004 Parameter IN_INV, {N_CH{1'b0}}, per-channel bitmask; a set bit inverts that raw input before synchronisation.
REQ-005 Parameter RPT_DELAY, 500, ticks from accepted press to first repeat pulse (>=1).
REQ-006 Parameter RPT_RATE, 100, ticks between subsequent repeat pulses (>=1).
REQ-007 clk  input  1  single system clock; all state on rising edge.
REQ-008 rst_n  input  1  asynchronous, active-low reset.
REQ-009 raw_i  input  N_CH  asynchronous button/switch inputs.
REQ-010 level_o  output  N_CH  debounced level per channel.
REQ-011 press_o  output  N_CH  one-clk pulse when level_o rises.
REQ-012 release_o  output  N_CH  one-clk pulse when level_o falls.
REQ-013 rpt_o  output  N_CH  one-clk auto-repeat pulse while held.
REQ-014 tick_o  output  1  one-clk sample-tick strobe, exported for other blocks.

Function
REQ-015 Tick counter SHALL count 0..CLK_DIV-1, wrapping to 0; tick_o high exactly in the cycle the counter equals CLK_DIV-1; CLK_DIV=1 gives tick_o constantly high.
REQ-016 Each raw_i bit, after XOR with IN_INV, SHALL pass a 2-flop synchroniser in clk before any other logic.
REQ-017 Per channel, on each tick: if synchronised value != level_o, stable count increments; else count clears to 0.
REQ-018 When a tick finds a differing value and count == STABLE_TICKS-1, level_o SHALL toggle and count SHALL clear on that same edge.
REQ-019 A deviation lasting fewer than STABLE_TICKS consecutive ticks SHALL never change level_o.
REQ-020 press_o/release_o SHALL assert on the same clk edge that level_o changes and deassert the next cycle; never both high on one channel.
REQ-021 Worst-case latency from stable raw change to level_o change: 2 + CLK_DIV*STABLE_TICKS clk cycles; minimum 2 + CLK_DIV*(STABLE_TICKS-1) + 1.
REQ-022 Channels SHALL be fully independent; simultaneous events on several channels produce simultaneous pulses.
REQ-023 Counter widths SHALL be $clog2 of their maximum +1 bit as needed; no counter SHALL wrap past its terminal value.

Reset
REQ-024 While rst_n low: all counters, synchroniser flops, level_o, press_o, release_o, rpt_o, tick_o = 0.
REQ-025 Reset asserted mid-debounce SHALL discard the partial count; no pulse emitted on reset entry or exit.
REQ-026 A channel held high (after IN_INV) across reset release SHALL be debounced normally and produce one press_o.

Configuration
REQ-027 Macro INPUT_CONDITIONER_AUTO_REPEAT_EN: when defined, a per-channel repeat counter runs while level_o high; rpt_o pulses on the tick completing RPT_DELAY ticks after press, then every RPT_RATE ticks; cleared on release.
REQ-028 When undefined: rpt_o tied to 0, repeat counters absent; all other behaviour identical.

Structure
REQ-029 Shared package input_pkg SHALL hold default constants (CLK_DIV, STABLE_TICKS, RPT_DELAY, RPT_RATE) and a channel-index enum (CH_UP, CH_RIGHT, CH_DOWN, CH_LEFT, CH_SEL).
REQ-030 One sub-module debounce_channel (synchroniser, stable counter, edge pulses, optional repeat) SHALL be instantiated N_CH times via generate; tick generator stays in the top.

Verification (bench parameters CLK_DIV=4, STABLE_TICKS=3, RPT_DELAY=5, RPT_RATE=2)
REQ-031 raw_i[0] 0->1 held -> level_o[0] rises within 2+12 clk; press_o[0] exactly one cycle high, same edge.
REQ-032 raw_i[1] high-glitch lasting 8 clk (2 ticks) -> level_o[1], press_o[1] stay 0.
REQ-033 raw_i[2] held high 40 ticks with macro defined -> rpt_o[2] pulses at ticks 5, 7, 9, ... after press; without macro rpt_o constant 0.
REQ-034 All five channels toggled on the same cycle -> all press_o bits pulse on the same edge; release likewise.
REQ-035 rst_n pulled low after 2 stable ticks of a rising input, then released with input still high -> no pulse during reset, one press_o after full re-debounce.
REQ-036 IN_INV=5'b00001, raw_i[0] held 0 from reset -> level_o[0]=1 and one press_o[0] after debounce.
